lsu_subword: RTL and testbench

Load/store unit placed directly upstream of the word-only data memory. It accepts byte-addressed load/store requests of byte, halfword or word size from the execute stage. It converts each request into word-aligned `memread`/`memwrite` cycles on the memory port, and performs read-modify-write for sub-word stores. It returns load data aligned and sign- or zero-extended, and flags misaligned or illegal requests without touching memory.

---
 rtl/lsu_subword.sv | 137 +++++++++++++
 tb/tb_lsu_subword.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword.sv
// Sub-word load/store unit in front of a word-only registered data memory.
// Handles byte/half/word access, read-modify-write stores and misalignment rejection.
module lsu_subword #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W+1:0] byte_addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [31:0]       mem_readdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [1:0]        off_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       merge_reg;
  logic              mis_reg;
  logic [31:0]       rdata_reg;

  logic        accept;
  logic        bad;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = (state_reg == IDLE) && req;
  assign bad    = (size == 2'b11) ||
                  (size == 2'b01 && byte_addr[0]) ||
                  (size == 2'b10 && byte_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (bad)               state_next = DONE;
          else if (!we)          state_next = RD;
          else if (size == 2'b10) state_next = WR;
          else                   state_next = RD;
        end
      end
      RD:      state_next = CAP;
      CAP:     state_next = we_reg ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_reg != IDLE);
    done          = (state_reg == DONE);
    misalign      = (state_reg == DONE) && mis_reg;
    mem_memread   = (state_reg == RD);
    mem_memwrite  = (state_reg == WR);
    mem_address   = addr_reg;
    mem_writedata = merge_reg;
    rdata         = rdata_reg;
  end

  // Little-endian lane extraction from the word captured in CAP.
  always_comb begin
    lane_byte = 8'h00;
    lane_half = off_reg[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    case (off_reg)
      2'd0:    lane_byte = mem_readdata[7:0];
      2'd1:    lane_byte = mem_readdata[15:8];
      2'd2:    lane_byte = mem_readdata[23:16];
      default: lane_byte = mem_readdata[31:24];
    endcase
    case (size_reg)
      2'b00:   load_val = {{24{~uns_reg & lane_byte[7]}}, lane_byte};
      2'b01:   load_val = {{16{~uns_reg & lane_half[15]}}, lane_half};
      default: load_val = mem_readdata;
    endcase
  end

  // merge_reg still holds the latched store data when CAP is reached.
  always_comb begin
    merged = mem_readdata;
    if (size_reg == 2'b00)
      merged[{off_reg, 3'b000} +: 8] = merge_reg[7:0];
    else if (size_reg == 2'b01)
      merged[{off_reg[1], 4'b0000} +: 16] = merge_reg[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
      off_reg   <= 2'b00;
      addr_reg  <= '0;
      merge_reg <= 32'h0;
      mis_reg   <= 1'b0;
      rdata_reg <= 32'h0;
    end else begin
      if (accept) begin
        we_reg    <= we;
        size_reg  <= size;
        uns_reg   <= unsigned_ld;
        off_reg   <= byte_addr[1:0];
        addr_reg  <= byte_addr[ADDR_W+1:2];
        merge_reg <= wdata;
        mis_reg   <= bad;
      end
      if (state_reg == CAP) begin
        if (we_reg) merge_reg <= merged;
        else        rdata_reg <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Scoreboard bench for lsu_subword: stimulus pushes expectations, a monitor checks
// every done pulse and every memory strobe against them.
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [11:0] byte_addr = 12'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misalign, mem_memread, mem_memwrite;
  logic [31:0] rdata, mem_writedata;
  logic [31:0] mem_readdata = 32'h0;
  logic [9:0]  mem_address;

  logic [31:0] mem [0:1023];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wdat;
    logic [9:0]  addr;
  } exp_t;

  exp_t sb_q[$];

  lsu_subword #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .byte_addr(byte_addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .misalign(misalign),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Registered word memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_memwrite) mem[mem_address] <= mem_writedata;
    if (mem_memread)  mem_readdata <= mem[mem_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor
  int lat_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      lat_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    end else begin
      if (busy) lat_cnt++;
      if (mem_memread && mem_memwrite) chk("strobe_overlap", 32'd1, 32'd0);
      if (mem_memread || mem_memwrite) begin
        if (sb_q.size() == 0) chk("strobe_without_txn", 32'd1, 32'd0);
        else begin
          chk("mem_address", {22'h0, mem_address}, {22'h0, sb_q[0].addr});
          if (mem_memread) rd_cnt++;
          if (mem_memwrite) begin
            wr_cnt++;
            chk("mem_writedata", mem_writedata, sb_q[0].wdat);
          end
        end
      end
      if (done) begin
        if (sb_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("misalign", {31'h0, misalign}, {31'h0, e.mis});
          chk("latency", lat_cnt, e.lat);
          chk("read_strobes", rd_cnt, e.nrd);
          chk("write_strobes", wr_cnt, e.nwr);
        end
        lat_cnt = 0; rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] e_rd, input logic e_mis, input int e_lat,
                       input int e_nrd, input int e_nwr, input logic [31:0] e_wd);
    exp_t e;
    int t;
    @(negedge clk);
    t = 0;
    while (busy && t < 20) begin @(negedge clk); t++; end
    e.rdata = e_rd; e.mis = e_mis; e.lat = e_lat;
    e.nrd = e_nrd; e.nwr = e_nwr; e.wdat = e_wd; e.addr = a[11:2];
    sb_q.push_back(e);
    req = 1'b1; we = w; size = sz; unsigned_ld = u; byte_addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic txn(input string name, input logic w, input logic [1:0] sz, input logic u,
                     input logic [11:0] a, input logic [31:0] d,
                     input logic [31:0] e_rd, input logic e_mis, input int e_lat,
                     input int e_nrd, input int e_nwr, input logic [31:0] e_wd);
    issue(w, sz, u, a, d, e_rd, e_mis, e_lat, e_nrd, e_nwr, e_wd);
    wait_done(name);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    //   name       we size u addr    wdata          exp_rdata      mis lat rd wr exp_wdata
    txn("st_word",   1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 32'h00000000, 0, 2, 0, 1, 32'hDEADBEEF);
    txn("ld_word",   0, 2'b10, 0, 12'h010, 32'h0,        32'hDEADBEEF, 0, 3, 1, 0, 32'h0);
    txn("st_word20", 1, 2'b10, 0, 12'h020, 32'h80FF7F01, 32'hDEADBEEF, 0, 2, 0, 1, 32'h80FF7F01);
    txn("ld_sb23",   0, 2'b00, 0, 12'h023, 32'h0,        32'hFFFFFF80, 0, 3, 1, 0, 32'h0);
    txn("ld_ub22",   0, 2'b00, 1, 12'h022, 32'h0,        32'h000000FF, 0, 3, 1, 0, 32'h0);
    txn("ld_sh20",   0, 2'b01, 0, 12'h020, 32'h0,        32'h00007F01, 0, 3, 1, 0, 32'h0);
    txn("ld_sh22",   0, 2'b01, 0, 12'h022, 32'h0,        32'hFFFF80FF, 0, 3, 1, 0, 32'h0);
    txn("ld_uh22",   0, 2'b01, 1, 12'h022, 32'h0,        32'h000080FF, 0, 3, 1, 0, 32'h0);
    txn("ld_ub20",   0, 2'b00, 1, 12'h020, 32'h0,        32'h00000001, 0, 3, 1, 0, 32'h0);
    txn("st_word30", 1, 2'b10, 0, 12'h030, 32'h11223344, 32'h00000001, 0, 2, 0, 1, 32'h11223344);
    txn("st_byte31", 1, 2'b00, 0, 12'h031, 32'h000000AA, 32'h00000001, 0, 4, 1, 1, 32'h1122AA44);
    txn("ld_word30", 0, 2'b10, 0, 12'h030, 32'h0,        32'h1122AA44, 0, 3, 1, 0, 32'h0);
    txn("st_half32", 1, 2'b01, 0, 12'h032, 32'h1234BEEF, 32'h1122AA44, 0, 4, 1, 1, 32'hBEEFAA44);
    txn("ld_word30b",0, 2'b10, 0, 12'h030, 32'h0,        32'hBEEFAA44, 0, 3, 1, 0, 32'h0);
    txn("mis_word",  0, 2'b10, 0, 12'h005, 32'h0,        32'hBEEFAA44, 1, 1, 0, 0, 32'h0);
    txn("mis_size3", 1, 2'b11, 0, 12'h000, 32'h55,       32'hBEEFAA44, 1, 1, 0, 0, 32'h0);
    txn("mis_half",  1, 2'b01, 0, 12'h001, 32'h55,       32'hBEEFAA44, 1, 1, 0, 0, 32'h0);

    // Store request pulsed during CAP of a load must be dropped.
    issue(0, 2'b10, 0, 12'h010, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0, 32'h0);
    @(posedge clk);
    #1 req = 1'b1; we = 1'b1; size = 2'b00; byte_addr = 12'h010; wdata = 32'h00000055;
    @(posedge clk);
    #1 req = 1'b0;
    wait_done("busy_ld");
    repeat (4) @(negedge clk);
    txn("ld_after_ignore", 0, 2'b10, 0, 12'h010, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0, 32'h0);

    // Reset during RD of a load.
    issue(0, 2'b10, 0, 12'h020, 32'h0, 32'h80FF7F01, 0, 3, 1, 0, 32'h0);
    @(negedge clk);
    chk("rd_before_reset", {31'h0, mem_memread}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_memread", {31'h0, mem_memread}, 32'h0);
    chk("rst_memwrite", {31'h0, mem_memwrite}, 32'h0);
    chk("rst_address", {22'h0, mem_address}, 32'h0);
    chk("rst_writedata", mem_writedata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn("ld_after_reset", 0, 2'b10, 0, 12'h010, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0, 32'h0);
    txn("mis_after_reset",0, 2'b10, 0, 12'h006, 32'h0, 32'hDEADBEEF, 1, 1, 0, 0, 32'h0);

    repeat (3) @(negedge clk);
    chk("pending_txns", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
